task_msg_framer: RTL and testbench

//  Byte-stream front end for the task message path. Packs inbound bytes into 32-bit

---
 rtl/task_msg_framer.sv | 150 +++++++++++++++
 tb/tb_task_msg_framer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/task_msg_framer.sv
// Byte-stream framer for the task message path: packs big-endian bytes into words, frames
// one message on the header LEN field, and hands message plus verdict to the dispatcher.
module task_msg_framer #(
    parameter int  TIMEOUT_CYCLES = 1000,
    localparam int MAX_MSG_WORDS  = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [MAX_MSG_WORDS*32-1:0]  m_words,
    output logic [3:0]                   m_len,
    output logic [31:0]                  m_status,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         timeout_err
);

    localparam int          HEADER_WORDS    = 4;
    localparam int          LEN_IDX         = 0;
    localparam int          TASK_ID_IDX     = 2;
    localparam int          STATUS_IDX      = 3;
    localparam logic [7:0]  TASK_ID_BANK    = 8'd100;
    localparam logic [7:0]  TASK_ID_OUT     = 8'd101;
    localparam logic [31:0] TASK_VALID      = 32'd0;
    localparam logic [31:0] HEADER_INVALID  = 32'd1;
    localparam logic [31:0] PAYLOAD_INVALID = 32'd2;
    localparam int          IDLE_W          = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_HDR, ST_PAY, ST_OUT} state_t;

    function automatic logic f_len_ok(input logic [31:0] len);
        return (len >= 32'(HEADER_WORDS)) && (len <= 32'(MAX_MSG_WORDS));
    endfunction

    function automatic logic [31:0] f_verdict(input logic [31:0] len, input logic [31:0] task_id,
                                              input logic [31:0] stat);
        if (!f_len_ok(len) || (task_id[31:8] != 24'd0) ||
            ((task_id[7:0] != TASK_ID_BANK) && (task_id[7:0] != TASK_ID_OUT)) ||
            (stat != TASK_VALID))
            return HEADER_INVALID;
        if (((task_id[7:0] == TASK_ID_BANK) && (len != 32'd6)) ||
            ((task_id[7:0] == TASK_ID_OUT) && (len != 32'd5)))
            return PAYLOAD_INVALID;
        return TASK_VALID;
    endfunction

    state_t                       r_state;
    logic [MAX_MSG_WORDS*32-1:0]  r_words;
    logic [1:0]                   r_byte_cnt;
    logic [3:0]                   r_word_cnt;
    logic [3:0]                   r_len;
    logic [31:0]                  r_status;
    logic [IDLE_W-1:0]            r_idle;
    logic                         r_s_ready;
    logic                         r_m_valid;
    logic                         r_timeout;

    logic        w_accept, w_hdr_done, w_pay_done, w_empty, w_go_out;
    logic [8:0]  w_bit_base;
    logic [31:0] w_len_word, w_task_word, w_stat_word;

    assign w_accept    = s_valid & r_s_ready;
    // byte b of word w lands at bit w*32 + (3-b)*8 (big-endian within the word)
    assign w_bit_base  = {r_word_cnt, ~r_byte_cnt, 3'b000};
    assign w_len_word  = r_words[LEN_IDX*32 +: 32];
    assign w_task_word = r_words[TASK_ID_IDX*32 +: 32];
    assign w_stat_word = {r_words[STATUS_IDX*32+8 +: 24], s_data};
    assign w_hdr_done  = (r_word_cnt == 4'(HEADER_WORDS - 1)) && (r_byte_cnt == 2'd3);
    assign w_pay_done  = (r_word_cnt == r_len - 4'd1) && (r_byte_cnt == 2'd3);
    assign w_empty     = (r_word_cnt == 4'd0) && (r_byte_cnt == 2'd0);
    assign w_go_out    = w_accept &&
                         (((r_state == ST_HDR) && w_hdr_done &&
                           (!f_len_ok(w_len_word) || (w_len_word[3:0] == 4'(HEADER_WORDS)))) ||
                          ((r_state == ST_PAY) && w_pay_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HDR;
            r_words    <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_status   <= TASK_VALID;
            r_idle     <= '0;
            r_s_ready  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                ST_HDR, ST_PAY: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_words[w_bit_base +: 8] <= s_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_idle     <= '0;
                        if (r_byte_cnt == 2'd3)
                            r_word_cnt <= r_word_cnt + 4'd1;
                        if ((r_state == ST_HDR) && w_hdr_done) begin
                            r_status <= f_verdict(w_len_word, w_task_word, w_stat_word);
                            r_len    <= f_len_ok(w_len_word) ? w_len_word[3:0] : 4'(HEADER_WORDS);
                        end
                        if (w_go_out) begin
                            r_state   <= ST_OUT;
                            r_m_valid <= 1'b1;
                            r_s_ready <= 1'b0;
                        end else if ((r_state == ST_HDR) && w_hdr_done) begin
                            r_state <= ST_PAY;
                        end
                    end else if ((r_state == ST_HDR) && w_empty) begin
                        r_idle <= '0;
                    end else if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        // stalled mid-message: drop the partial data and resync on a fresh header
                        r_state    <= ST_HDR;
                        r_words    <= '0;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_idle     <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                ST_OUT: begin
                    r_idle    <= '0;
                    r_s_ready <= 1'b0;
                    if (m_ready) begin
                        r_state    <= ST_HDR;
                        r_m_valid  <= 1'b0;
                        r_words    <= '0;
                        r_byte_cnt <= '0;
                        r_word_cnt <= '0;
                        r_s_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign m_words     = r_words;
    assign m_len       = r_len;
    assign m_status    = r_status;
    assign m_valid     = r_m_valid;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_task_msg_framer.sv
// Directed, table-driven bench for task_msg_framer with hand-written backpressure,
// timeout and mid-message reset sequences.
module tb_task_msg_framer;

    localparam int          TO         = 1000;
    localparam logic [31:0] ST_VALID   = 32'd0;
    localparam logic [31:0] ST_HDR_INV = 32'd1;
    localparam logic [31:0] ST_PAY_INV = 32'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic [383:0] m_words;
    logic [3:0]   m_len;
    logic [31:0]  m_status;
    logic         m_valid;
    logic         m_ready;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    task_msg_framer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_words(m_words), .m_len(m_len), .m_status(m_status), .m_valid(m_valid),
        .m_ready(m_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] len, seq, tid, stat, seed;
        logic [3:0]  exp_len;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int n_pay(input vec_t v);
        if (v.len >= 32'd4 && v.len <= 32'd12) return int'(v.len) - 4;
        return 0;
    endfunction

    function automatic logic [31:0] msg_word(input vec_t v, input int w);
        case (w)
            0: return v.len;
            1: return v.seq;
            2: return v.tid;
            3: return v.stat;
            default: return v.seed + 32'(w - 4) * 32'h10101010;
        endcase
    endfunction

    function automatic logic [383:0] exp_words(input vec_t v);
        logic [383:0] e = '0;
        for (int w = 0; w < 4 + n_pay(v); w++) e[w*32 +: 32] = msg_word(v, w);
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        s_data  = b;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL s_ready_wait: got 0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input vec_t v);
        logic [31:0] wd;
        for (int w = 0; w < 4 + n_pay(v); w++) begin
            wd = msg_word(v, w);
            for (int b = 0; b < 4; b++) send_byte(wd[31-8*b -: 8]);
        end
    endtask

    task automatic release_msg(input string tag);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk({tag, "_rel_mvalid"}, m_valid, 1'b0);
        chk({tag, "_rel_words"}, m_words, '0);
        chk({tag, "_rel_sready"}, s_ready, 1'b1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        send_msg(v);
        s_valid = 1'b0;
        chk({tag, "_latency"}, m_valid, 1'b1);
        chk({tag, "_len"}, m_len, v.exp_len);
        chk({tag, "_status"}, m_status, v.exp_status);
        chk({tag, "_words"}, m_words, exp_words(v));
        chk({tag, "_sready"}, s_ready, 1'b0);
        release_msg(tag);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sready"}, s_ready, 1'b0);
        chk({tag, "_mvalid"}, m_valid, 1'b0);
        chk({tag, "_words"}, m_words, '0);
        chk({tag, "_len"}, m_len, 4'd0);
        chk({tag, "_status"}, m_status, ST_VALID);
        chk({tag, "_tmo"}, timeout_err, 1'b0);
    endtask

    initial begin
        logic [383:0] cap_words;
        logic [3:0]   cap_len;
        logic [31:0]  cap_status;
        int           unstable, pulses, first_at;
        vec_t         vout;

        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        //          len        seq    task_id      status  seed          m_len  verdict
        vecs[0]  = '{32'd6,    32'h11, 32'd100,     32'd0, 32'hA0A1A2A3, 4'd6,  ST_VALID};
        vecs[1]  = '{32'd13,   32'h12, 32'd100,     32'd0, 32'h0,        4'd4,  ST_HDR_INV};
        vecs[2]  = '{32'd5,    32'h13, 32'd100,     32'd0, 32'hC0C1C2C3, 4'd5,  ST_PAY_INV};
        vecs[3]  = '{32'd5,    32'h14, 32'h165,     32'd0, 32'hD0D1D2D3, 4'd5,  ST_HDR_INV};
        vecs[4]  = '{32'd5,    32'h15, 32'd101,     32'd0, 32'h01020304, 4'd5,  ST_VALID};
        vecs[5]  = '{32'd4,    32'h16, 32'd100,     32'd0, 32'h0,        4'd4,  ST_PAY_INV};
        vecs[6]  = '{32'd3,    32'h17, 32'd100,     32'd0, 32'h0,        4'd4,  ST_HDR_INV};
        vecs[7]  = '{32'd12,   32'h18, 32'd101,     32'd0, 32'h11223344, 4'd12, ST_PAY_INV};
        vecs[8]  = '{32'd6,    32'h19, 32'd100,     32'd1, 32'h55667788, 4'd6,  ST_HDR_INV};
        vecs[9]  = '{32'd6,    32'h1A, 32'd102,     32'd0, 32'h99AABBCC, 4'd6,  ST_HDR_INV};
        vecs[10] = '{32'h106,  32'h1B, 32'd100,     32'd0, 32'h0,        4'd4,  ST_HDR_INV};
        vecs[11] = '{32'd5,    32'h1C, 32'h00010065, 32'd0, 32'hCAFEF00D, 4'd5, ST_HDR_INV};
        vecs[12] = '{32'd4,    32'h1D, 32'd101,     32'd2, 32'h0,        4'd4,  ST_HDR_INV};
        vout     = '{32'd5,    32'h2A, 32'd101,     32'd0, 32'h0BADBEEF, 4'd5,  ST_VALID};

        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Dispatcher holds off for 50 cycles while the source keeps offering a byte.
        send_msg(vecs[0]);
        s_data = 8'h00;
        cap_words = m_words; cap_len = m_len; cap_status = m_status;
        chk("bp_words", cap_words, exp_words(vecs[0]));
        unstable = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_words !== cap_words ||
                m_len !== cap_len || m_status !== cap_status) unstable++;
        end
        chk("bp_unstable_cycles", unstable, 0);
        s_valid = 1'b0;
        release_msg("bp");
        @(posedge clk);
        #1;
        chk("bp_single_xfer", m_valid, 1'b0);

        // Stall after 7 bytes: exactly one timeout pulse, TO cycles after the last byte.
        for (int b = 0; b < 7; b++) send_byte(8'h40 + 8'(b));
        s_valid = 1'b0;
        pulses = 0; first_at = 0;
        for (int k = 1; k <= TO + 50; k++) begin
            @(posedge clk);
            #1;
            if (timeout_err) begin
                pulses++;
                if (first_at == 0) first_at = k;
            end
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_cycle", first_at, TO);
        chk("tmo_no_msg", m_valid, 1'b0);
        run_vec("after_tmo", vout);

        // An empty HDR never times out.
        pulses = 0;
        for (int k = 0; k < TO + 50; k++) begin
            @(posedge clk);
            #1;
            if (timeout_err) pulses++;
        end
        chk("idle_empty_pulses", pulses, 0);

        // Reset in the middle of the payload, mid-word.
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++)
                if (w < 4 || b < 2) send_byte(msg_word(vecs[0], w) >> (24 - 8*b));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("rst_mid");
        rst = 1'b0;
        s_valid = 1'b0;
        run_vec("after_rst", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
